block_reorder_out: RTL and testbench



---
 rtl/idct_pkg.sv | 11 +
 rtl/block_reorder_out_if.sv | 13 +
 rtl/reorder_ram.sv | 20 ++
 rtl/block_reorder_out.sv | 106 ++++++++++
 tb/tb_block_reorder_out.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/idct_pkg.sv
// idct_pkg: shared sample/frame constants, bank state and write-address permutation
package idct_pkg;
    localparam int DATA_W = 16;
    localparam int BLK_N = 64;
    localparam logic MODE_8X8 = 1'b1;
    localparam logic MODE_4X4 = 1'b0;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;
    function automatic logic [5:0] perm_addr(input logic [5:0] k, input logic mode);
        return mode == MODE_4X4 ? {k[5:4], k[1:0], k[3:2]} : {k[2:0], k[5:3]};
    endfunction
endpackage

// File: rtl/block_reorder_out_if.sv
// block_reorder_out_if: column-order sample input stream and raster-order output stream
interface block_reorder_out_if #(parameter int DATA_W = idct_pkg::DATA_W);
    logic in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, out_last;
    logic [DATA_W-1:0] in_data, out_data;
    modport slave (
        input in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode, out_last
    );
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input in_ready, out_valid, out_data, out_mode, out_last
    );
endinterface

// File: rtl/reorder_ram.sv
// reorder_ram: one frame of sample storage, one write port and one registered read port
module reorder_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/block_reorder_out.sv
// block_reorder_out: ping-pong column-to-raster reorder buffer; BLOCK_REORDER_OUT_SAT_EN saturates samples to signed 9-bit
module block_reorder_out #(
    parameter int DATA_W = idct_pkg::DATA_W,
    parameter int BLK_N = idct_pkg::BLK_N
) (
    input logic clk,
    input logic rst,
    block_reorder_out_if.slave bus
);
    import idct_pkg::*;
    localparam int AW = $clog2(BLK_N);
    bank_state_t st [2];
    bank_state_t st_nx [2];
    logic [1:0] mode_q;
    logic wr_bank, rd_bank, fr_bank;
    logic [AW-1:0] wr_cnt, rd_cnt;
    logic in_hs, out_hs, rd_iss, a_keep, wr_mode, wr_last, rd_end;
    logic [DATA_W-1:0] wr_data, rd_q, sk_data;
    logic [DATA_W-1:0] ram_q [2];
    logic rd_v, rd_last, rd_mode, rd_sel, sk_v, sk_last, sk_mode;

    assign bus.in_ready = !rst && (st[wr_bank] == EMPTY || st[wr_bank] == FILLING);
    assign in_hs = bus.in_valid && bus.in_ready;
    assign out_hs = bus.out_valid && bus.out_ready;
    assign wr_last = wr_cnt == AW'(BLK_N - 1);
    assign rd_end = rd_cnt == AW'(BLK_N - 1);
    assign wr_mode = wr_cnt == '0 ? bus.in_mode : mode_q[wr_bank];
    // The RAM output register is the head of a 2-entry queue; the skid holds the older entry.
    assign a_keep = rd_v && !(out_hs && !sk_v);
    assign rd_iss = (st[rd_bank] == FULL || st[rd_bank] == DRAINING) && !(sk_v && rd_v && !bus.out_ready);
    assign rd_q = ram_q[rd_sel];
    assign bus.out_valid = sk_v || rd_v;
    assign bus.out_data = sk_v ? sk_data : rd_v ? rd_q : '0;
    assign bus.out_mode = sk_v ? sk_mode : rd_mode;
    assign bus.out_last = sk_v ? sk_last : rd_last;

`ifdef BLOCK_REORDER_OUT_SAT_EN
    assign wr_data = $signed(bus.in_data) > 255 ? DATA_W'(255) :
                     $signed(bus.in_data) < -256 ? DATA_W'(-256) : bus.in_data;
`else
    assign wr_data = bus.in_data;
`endif

    for (genvar i = 0; i < 2; i++) begin : g_bank
        reorder_ram #(.DATA_W(DATA_W), .DEPTH(BLK_N)) u_ram (
            .clk(clk),
            .we(in_hs && wr_bank == 1'(i)),
            .waddr(perm_addr(wr_cnt, wr_mode)),
            .wdata(wr_data),
            .re(rd_iss && rd_bank == 1'(i)),
            .raddr(rd_cnt),
            .rdata(ram_q[i])
        );
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_nx[i] = st[i];
            if (in_hs && wr_bank == 1'(i)) st_nx[i] = wr_last ? FULL : FILLING;
            if (rd_iss && rd_bank == 1'(i)) st_nx[i] = DRAINING;
            if (out_hs && bus.out_last && fr_bank == 1'(i)) st_nx[i] = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= '{EMPTY, EMPTY};
            mode_q <= {2{MODE_8X8}};
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            fr_bank <= 1'b0;
            wr_cnt <= '0;
            rd_cnt <= '0;
            rd_v <= 1'b0;
            rd_last <= 1'b0;
            rd_mode <= MODE_8X8;
            rd_sel <= 1'b0;
            sk_v <= 1'b0;
            sk_last <= 1'b0;
            sk_mode <= MODE_8X8;
            sk_data <= '0;
        end else begin
            st <= st_nx;
            if (in_hs) begin
                wr_cnt <= wr_cnt + AW'(1);
                wr_bank <= wr_last ? !wr_bank : wr_bank;
                if (wr_cnt == '0) mode_q[wr_bank] <= bus.in_mode;
            end
            if (rd_iss) begin
                rd_cnt <= rd_cnt + AW'(1);
                rd_bank <= rd_end ? !rd_bank : rd_bank;
                rd_last <= rd_end;
                rd_mode <= mode_q[rd_bank];
                rd_sel <= rd_bank;
            end
            if (out_hs && bus.out_last) fr_bank <= !fr_bank;
            rd_v <= rd_iss || a_keep;
            if (rd_iss && a_keep) begin
                sk_v <= 1'b1;
                {sk_data, sk_mode, sk_last} <= {rd_q, rd_mode, rd_last};
            end else if (out_hs && sk_v) begin
                sk_v <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_block_reorder_out.sv
// tb_block_reorder_out: randomized frames against a transpose/tile reference model of the reorder buffer
module tb_block_reorder_out;
    localparam int W = 16;
    typedef struct packed {logic [W-1:0] d; logic m; logic l;} smp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    block_reorder_out_if #(.DATA_W(W)) bus ();
    block_reorder_out #(.DATA_W(W), .BLK_N(64)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    smp_t src_q[$];
    smp_t exp_q[$];
    logic [W-1:0] frm [64];
    logic frm_mode;
    int k_in = 0, f_in = 0, f_out = 0, cyc = 0, n_out = 0, stalled = 0;
    int last_in_cyc = 0, first_valid_cyc = -1, first_out_cyc = -1, last_out_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_sat(input logic [W-1:0] x);
`ifdef BLOCK_REORDER_OUT_SAT_EN
        return $signed(x) > 255 ? W'(255) : $signed(x) < -256 ? W'(-256) : x;
`else
        return x;
`endif
    endfunction

    // Raster position a of a finished frame: 8x8 is a transpose, 4x4 transposes each 16-sample tile.
    task automatic model_in(input logic [W-1:0] d, input logic m);
        if (k_in == 0) frm_mode = m;
        frm[k_in] = d;
        k_in++;
        if (k_in == 64) begin
            for (int a = 0; a < 64; a++) begin
                int k;
                k = frm_mode ? (a % 8) * 8 + a / 8 : (a / 16) * 16 + (a % 4) * 4 + (a / 4) % 4;
                exp_q.push_back('{model_sat(frm[k]), frm_mode, a == 63});
            end
            k_in = 0;
            f_in++;
        end
    endtask

    task automatic gen_frame(input logic m, input bit rnd, input bit tog);
        for (int k = 0; k < 64; k++)
            src_q.push_back('{rnd ? W'($urandom) : W'(k),
                              k == 0 ? m : tog ? (k < 10 ? m : !m) : rnd ? 1'($urandom) : m, 1'b0});
    endtask

    task automatic mark();
        first_valid_cyc = -1;
        first_out_cyc = -1;
    endtask

    task automatic cycle(input int p_in, input int p_out);
        smp_t s, e;
        @(negedge clk);
        s = src_q.size() > 0 ? src_q[0] : '0;
        bus.in_valid = src_q.size() > 0 && int'($urandom_range(99)) < p_in;
        bus.in_data = bus.in_valid ? s.d : W'($urandom);
        bus.in_mode = bus.in_valid ? s.m : 1'($urandom);
        bus.out_ready = int'($urandom_range(99)) < p_out;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(f_in - f_out < 2));
        if (bus.in_valid && !bus.in_ready) stalled = 1;
        if (bus.in_valid && bus.in_ready) begin
            void'(src_q.pop_front());
            model_in(s.d, s.m);
            if (k_in == 0) last_in_cyc = cyc;
        end
        if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            last_out_cyc = cyc;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            if (exp_q.size() == 0) chk("spurious_out", 32'(bus.out_valid), 32'(0));
            else begin
                e = exp_q.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(e.d));
                chk("out_mode", 32'(bus.out_mode), 32'(e.m));
                chk("out_last", 32'(bus.out_last), 32'(e.l));
                if (e.l) f_out++;
            end
        end
        cyc++;
    endtask

    task automatic run(input int p_in, input int p_out, input int budget);
        int n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            cycle(p_in, p_out);
            n++;
        end
        chk("drain", 32'(src_q.size() + exp_q.size()), 32'(0));
    endtask

    initial begin
        int n, f0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_mode = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_data", 32'(bus.out_data), 32'(0));
        chk("rst_out_mode", 32'(bus.out_mode), 32'(1));
        chk("rst_out_last", 32'(bus.out_last), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1 chk("in_ready_after_rst", 32'(bus.in_ready), 32'(1));

        mark();
        gen_frame(1'b1, 1'b0, 1'b0);
        run(100, 100, 400);
        chk("latency_8x8", 32'(first_valid_cyc - last_in_cyc), 32'(2));

        gen_frame(1'b0, 1'b0, 1'b0);
        run(100, 100, 400);
        gen_frame(1'b1, 1'b0, 1'b1);
        run(100, 100, 400);

        mark();
        gen_frame(1'b1, 1'b1, 1'b0);
        gen_frame(1'b0, 1'b1, 1'b0);
        run(100, 100, 600);
        chk("b2b_span", 32'(last_out_cyc - first_out_cyc), 32'(127));

        n_out = 0;
        stalled = 0;
        for (int i = 0; i < 3; i++) gen_frame(1'($urandom), 1'b1, 1'b0);
        run(100, 50, 3000);
        chk("bp_count", 32'(n_out), 32'(192));
        chk("bp_in_ready_dropped", 32'(stalled), 32'(1));

        gen_frame(1'b0, 1'b1, 1'b0);
        gen_frame(1'b1, 1'b1, 1'b0);
        run(60, 70, 2000);

        for (int k = 0; k < 64; k++)
            src_q.push_back('{k == 0 ? W'(300) : k == 1 ? W'(-300) : k == 2 ? W'(100) : W'(k), 1'b1, 1'b0});
        run(100, 100, 400);

        f0 = f_in;
        gen_frame(1'b1, 1'b0, 1'b0);
        gen_frame(1'b0, 1'b1, 1'b0);
        n = 0;
        while (!(f_in == f0 + 1 && k_in == 30) && n < 500) begin
            cycle(100, 30);
            n++;
        end
        chk("reach_k30", 32'(k_in), 32'(30));
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1 chk("in_ready_in_rst", 32'(bus.in_ready), 32'(0));
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("mid_rst_out_data", 32'(bus.out_data), 32'(0));
        chk("mid_rst_out_mode", 32'(bus.out_mode), 32'(1));
        chk("mid_rst_out_last", 32'(bus.out_last), 32'(0));
        rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        k_in = 0;
        f_in = 0;
        f_out = 0;
        #1 chk("in_ready_post_rst", 32'(bus.in_ready), 32'(1));
        mark();
        gen_frame(1'b0, 1'b1, 1'b0);
        run(100, 100, 400);
        chk("latency_post_rst", 32'(first_valid_cyc - last_in_cyc), 32'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
